// File: rtl/bram_load_arbiter.sv
// Round-robin arbiter that shares BRAM port 0 among NUM_LD load requesters.
// Each requester has a one-entry response buffer. Port 1 carries the single store stream straight through.
module bram_load_arbiter #(
    parameter int NUM_LD     = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LD*ADDR_WIDTH-1:0] ld_addr,
    input  logic [NUM_LD-1:0]            ld_addr_valid,
    output logic [NUM_LD-1:0]            ld_addr_ready,
    output logic [NUM_LD*DATA_WIDTH-1:0] ld_data,
    output logic [NUM_LD-1:0]            ld_data_valid,
    input  logic [NUM_LD-1:0]            ld_data_ready,
    input  logic [ADDR_WIDTH-1:0]        st_addr,
    input  logic [DATA_WIDTH-1:0]        st_data,
    input  logic                         st_valid,
    output logic                         st_ready,
    output logic                         ce0,
    output logic                         we0,
    output logic [ADDR_WIDTH-1:0]        address0,
    output logic [DATA_WIDTH-1:0]        dout0,
    input  logic [DATA_WIDTH-1:0]        din0,
    output logic                         ce1,
    output logic                         we1,
    output logic [ADDR_WIDTH-1:0]        address1,
    output logic [DATA_WIDTH-1:0]        dout1,
    output logic                         busy
);
    localparam int PTR_W = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;

    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [NUM_LD-1:0]            inflight_q, inflight_d;
    logic [PTR_W-1:0]             inflight_id_q, inflight_id_d;
    logic [NUM_LD-1:0]            resp_valid_q, resp_valid_d;
    logic [NUM_LD*DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [NUM_LD-1:0]            elig_s;
    logic                         grant_s;
    logic [PTR_W-1:0]             win_s;

    assign elig_s = ld_addr_valid & ~inflight_q & (~resp_valid_q | ld_data_ready);

    // Round-robin scan from rr_ptr; grants are suppressed while reset is held.
    always_comb begin : arb
        int idx;
        grant_s = 1'b0;
        win_s   = {PTR_W{1'b0}};
        idx     = 0;
        for (int k = 0; k < NUM_LD; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_LD) begin
                idx = idx - NUM_LD;
            end else begin
                idx = idx;
            end
            if (!grant_s && elig_s[idx] && !rst) begin
                grant_s = 1'b1;
                win_s   = PTR_W'(idx);
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Read-port drive and one-hot grant vector.
    always_comb begin
        ce0           = grant_s;
        address0      = {ADDR_WIDTH{1'b0}};
        ld_addr_ready = {NUM_LD{1'b0}};
        for (int i = 0; i < NUM_LD; i++) begin
            ld_addr_ready[i] = grant_s && (win_s == PTR_W'(i));
        end
        if (grant_s) begin
            address0 = ld_addr[win_s*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
            address0 = {ADDR_WIDTH{1'b0}};
        end
    end

    // Next state: pointer advance, read tracking, response capture/consume.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        inflight_id_d = inflight_id_q;
        inflight_d    = {NUM_LD{1'b0}};
        resp_valid_d  = resp_valid_q;
        resp_data_d   = resp_data_q;
        if (grant_s) begin
            rr_ptr_d      = (win_s == PTR_W'(NUM_LD - 1)) ? {PTR_W{1'b0}} : win_s + 1'b1;
            inflight_id_d = win_s;
        end else begin
            rr_ptr_d      = rr_ptr_q;
            inflight_id_d = inflight_id_q;
        end
        for (int i = 0; i < NUM_LD; i++) begin
            inflight_d[i] = grant_s && (win_s == PTR_W'(i));
            // A capture wins over a same-cycle consume: the buffer stays full with new data.
            if (inflight_q[i] && (inflight_id_q == PTR_W'(i))) begin
                resp_valid_d[i]                         = 1'b1;
                resp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = din0;
            end else if (resp_valid_q[i] && ld_data_ready[i]) begin
                resp_valid_d[i] = 1'b0;
            end else begin
                resp_valid_d[i] = resp_valid_q[i];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q      <= {PTR_W{1'b0}};
            inflight_q    <= {NUM_LD{1'b0}};
            inflight_id_q <= {PTR_W{1'b0}};
            resp_valid_q  <= {NUM_LD{1'b0}};
            resp_data_q   <= {(NUM_LD*DATA_WIDTH){1'b0}};
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
        end
    end

    assign ld_data       = resp_data_q;
    assign ld_data_valid = resp_valid_q;
    assign busy          = (|inflight_q) | (|resp_valid_q);
    assign we0           = 1'b0;
    assign dout0         = {DATA_WIDTH{1'b0}};
    assign st_ready      = 1'b1;
    assign ce1           = st_valid;
    assign we1           = st_valid;
    assign address1      = st_addr;
    assign dout1         = st_data;

endmodule

// File: tb/tb_bram_load_arbiter.sv
// Directed + randomized bench for bram_load_arbiter (3 requesters) against a transaction-level model.
module tb_bram_load_arbiter;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] ld_addr;
    logic [N-1:0]    ld_addr_valid, ld_addr_ready, ld_data_valid, ld_data_ready;
    logic [N*DW-1:0] ld_data;
    logic [AW-1:0]   st_addr, address0, address1;
    logic [DW-1:0]   st_data, dout0, din0, dout1;
    logic            st_valid, st_ready, ce0, we0, ce1, we1, busy;

    bram_load_arbiter #(.NUM_LD(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .ld_addr(ld_addr), .ld_addr_valid(ld_addr_valid),
        .ld_addr_ready(ld_addr_ready), .ld_data(ld_data), .ld_data_valid(ld_data_valid),
        .ld_data_ready(ld_data_ready), .st_addr(st_addr), .st_data(st_data),
        .st_valid(st_valid), .st_ready(st_ready), .ce0(ce0), .we0(we0),
        .address0(address0), .dout0(dout0), .din0(din0), .ce1(ce1), .we1(we1),
        .address1(address1), .dout1(dout1), .busy(busy)
    );

    always #5 clk = ~clk;

    // Read-first BRAM with one-cycle read latency.
    logic [DW-1:0] bram [16];
    always @(posedge clk) begin
        if (ce0) din0 <= bram[address0];
        if (we1) bram[address1] <= dout1;
    end

    // Staged stimulus, applied at each falling edge.
    logic [AW-1:0] s_addr [N];
    logic [N-1:0]  s_valid, s_ready;
    logic          s_stv;
    logic [AW-1:0] s_sta;
    logic [DW-1:0] s_std;

    // Transaction-level model: response buffers hold memory contents as of the grant cycle.
    int            m_ptr;
    logic [N-1:0]  m_infl, m_rv;
    logic [DW-1:0] m_rd [N];
    logic [DW-1:0] m_pd [N];
    logic [DW-1:0] m_mem [16];
    int            last_w;
    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            g [6];
    int            n1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_infl = '0;
        m_rv   = '0;
        for (int i = 0; i < N; i++) m_rd[i] = '0;
    endtask

    task automatic model_check();
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (w < 0 && s_valid[idx] && !m_infl[idx] && (!m_rv[idx] || s_ready[idx])) w = idx;
        end
        check("grant", 32'(ld_addr_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
        check("ce0", 32'(ce0), (w >= 0) ? 32'd1 : 32'd0);
        if (w >= 0) check("address0", 32'(address0), 32'(s_addr[w]));
        else        check("address0_idle", 32'(address0), 32'd0);
        check("ld_data_valid", 32'(ld_data_valid), 32'(m_rv));
        for (int i = 0; i < N; i++) check("ld_data", 32'(ld_data[i*DW +: DW]), 32'(m_rd[i]));
        check("busy", 32'(busy), 32'((|m_infl) || (|m_rv)));
        check("store_port", 32'({st_ready, ce1, we1, address1, dout1}),
              32'({1'b1, s_stv, s_stv, s_sta, s_std}));
        check("port0_write", 32'({we0, dout0}), 32'd0);
        for (int i = 0; i < N; i++) begin
            if (m_infl[i]) begin
                m_rv[i] = 1'b1;
                m_rd[i] = m_pd[i];
            end else if (m_rv[i] && s_ready[i]) begin
                m_rv[i] = 1'b0;
            end
        end
        m_infl = '0;
        last_w = w;
        if (w >= 0) begin
            m_infl[w] = 1'b1;
            m_pd[w]   = m_mem[s_addr[w]];
            m_ptr     = (w + 1) % N;
        end
        if (s_stv) m_mem[s_sta] = s_std;
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) ld_addr[i*AW +: AW] = s_addr[i];
        ld_addr_valid = s_valid;
        ld_data_ready = s_ready;
        st_valid = s_stv;
        st_addr  = s_sta;
        st_data  = s_std;
        #1;
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ld_addr_valid = '0;
        st_valid = 1'b0;
        s_valid = '0;
        s_stv = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        ld_addr = '0;
        ld_addr_valid = 3'b111;
        ld_data_ready = 3'b111;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        for (int i = 0; i < N; i++) s_addr[i] = '0;
        s_valid = '0; s_ready = 3'b111; s_stv = 1'b0; s_sta = '0; s_std = '0;
        model_reset();
        #1;
        check("rst_ld_data_valid", 32'(ld_data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ce0", 32'(ce0), 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        ld_addr_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // Preload memory through the store port.
        for (int a = 0; a < 16; a++) begin
            s_stv = 1'b1;
            s_sta = AW'(a);
            s_std = (a == 3) ? 8'h5A : DW'(a * 13 + 7);
            step();
        end
        s_stv = 1'b0;

        // Single requester: grant at t0, data at t0+2, re-grant at t0+2.
        s_addr[0] = 4'd3; s_valid = 3'b001;
        step();
        check("single_grant", 32'(ld_addr_ready), 32'd1);
        check("single_addr", 32'(address0), 32'd3);
        step();
        check("single_blocked", 32'(ld_addr_ready), 32'd0);
        step();
        check("single_valid", 32'(ld_data_valid[0]), 32'd1);
        check("single_data", 32'(ld_data[7:0]), 32'h5A);
        check("single_regrant", 32'(ld_addr_ready[0]), 32'd1);

        // Contention: alternating grants from reset.
        do_reset();
        s_addr[0] = 4'd1; s_addr[1] = 4'd2; s_valid = 3'b011; s_ready = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            g[k] = last_w;
        end
        for (int k = 0; k < 6; k++) check("contention_order", 32'(g[k]), 32'(k % 2));

        // Backpressure on requester 0.
        s_ready = 3'b110;
        n1 = 0;
        for (int j = 0; j < 7; j++) begin
            step();
            if (last_w == 1) n1++;
            if (j >= 2) begin
                check("bp_no_grant0", 32'(ld_addr_ready[0]), 32'd0);
                check("bp_hold_valid", 32'(ld_data_valid[0]), 32'd1);
                check("bp_hold_data", 32'(ld_data[7:0]), 32'h14);
            end
        end
        check("bp_req1_served", 32'(n1 >= 2), 32'd1);
        s_ready = 3'b111;
        step();
        check("bp_release_grant0", 32'(ld_addr_ready[0]), 32'd1);

        // Concurrent store and load on the same address.
        do_reset();
        s_addr[0] = 4'd3; s_valid = 3'b001;
        s_stv = 1'b1; s_sta = 4'd3; s_std = 8'h11;
        step();
        check("cs_we1", 32'(we1), 32'd1);
        check("cs_grant", 32'(ld_addr_ready), 32'd1);
        s_stv = 1'b0; s_addr[1] = 4'd3; s_valid = 3'b010;
        step();
        s_valid = 3'b000;
        step();
        check("cs_old_valid", 32'(ld_data_valid[0]), 32'd1);
        check("cs_old_data", 32'(ld_data[7:0]), 32'h5A);
        step();
        check("cs_new_data", 32'(ld_data[15:8]), 32'h11);

        // Wrap-around of the round-robin pointer.
        do_reset();
        s_addr[0] = 4'd5; s_addr[1] = 4'd6; s_addr[2] = 4'd7;
        s_valid = 3'b010; step();
        check("wrap_g1", 32'(ld_addr_ready), 32'b010);
        s_valid = 3'b101; step();
        check("wrap_g2", 32'(ld_addr_ready), 32'b100);
        step();
        check("wrap_g0", 32'(ld_addr_ready), 32'b001);
        s_valid = 3'b111; step();
        check("wrap_ptr1", 32'(ld_addr_ready), 32'b010);

        // Asynchronous reset the cycle after a grant.
        step();
        @(posedge clk);
        #2;
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(ld_data_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ce0", 32'(ce0), 32'd0);
        ld_addr_valid = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        s_valid = 3'b111;
        step();
        check("midrst_first_grant", 32'(ld_addr_ready), 32'b001);
        check("midrst_no_stale", 32'(ld_data_valid), 32'd0);

        // Randomized traffic.
        for (int r = 0; r < 400; r++) begin
            s_valid = 3'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                s_ready[i] = ($urandom_range(0, 3) != 0);
                s_addr[i]  = 4'($urandom_range(0, 15));
            end
            s_stv = ($urandom_range(0, 2) == 0);
            s_sta = 4'($urandom_range(0, 15));
            s_std = 8'($urandom_range(0, 255));
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/bram_load_arbiter.md
Name: bram_load_arbiter

Overview:
- Shares one dual-port BRAM between NUM_LD independent load requesters and one store requester, in the dynamatic-generated memory interface layer.
- Port 0 is the read port, arbitrated round-robin, 1-cycle BRAM read latency.
- Port 1 is the write port, carrying the single store stream.
- Each load requester gets valid/ready address and data channels, with a one-entry response buffer.

Parameters:
- NUM_LD, 2, number of load requesters (1..8)
- DATA_WIDTH, 8, BRAM word width
- ADDR_WIDTH, 4, BRAM address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ld_addr  in  NUM_LD*ADDR_WIDTH  load addresses, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- ld_addr_valid  in  NUM_LD  load request valid per requester
- ld_addr_ready  out  NUM_LD  load request accepted (grant)
- ld_data  out  NUM_LD*DATA_WIDTH  load response data, same slicing
- ld_data_valid  out  NUM_LD  response valid
- ld_data_ready  in  NUM_LD  response consumed
- st_addr  in  ADDR_WIDTH  store address
- st_data  in  DATA_WIDTH  store data
- st_valid  in  1  store request
- st_ready  out  1  store accepted
- ce0  out  1  BRAM port 0 enable
- we0  out  1  BRAM port 0 write enable, constant 0
- address0  out  ADDR_WIDTH  BRAM port 0 address
- dout0  out  DATA_WIDTH  BRAM port 0 write data, constant 0
- din0  in  DATA_WIDTH  BRAM port 0 read data, valid one cycle after ce0
- ce1  out  1  BRAM port 1 enable
- we1  out  1  BRAM port 1 write enable
- address1  out  ADDR_WIDTH  BRAM port 1 address
- dout1  out  DATA_WIDTH  BRAM port 1 write data
- busy  out  1  any load in flight or response pending

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=0; inflight, inflight_id, resp_valid all cleared; resp_data=0.
  - All outputs therefore 0: ld_data_valid, ce0, busy. st_ready is combinational and follows the store rules below.
  - Reset mid-operation discards in-flight reads and buffered responses; nothing is replayed.
- Per-requester state: resp_valid[i], resp_data[i], inflight[i] (a read issued last cycle, landing this cycle).
- Eligibility: elig[i] = ld_addr_valid[i] & !inflight[i] & (!resp_valid[i] | ld_data_ready[i]).
- Arbitration (combinational):
  - Winner is the first eligible index scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_LD.
  - At most one grant per cycle.
  - ld_addr_ready[w]=1 only for the winner w; all others 0.
  - On grant: ce0=1, address0=ld_addr slice w. No grant: ce0=0, address0=0.
- Pointer update: on grant, rr_ptr <= (w==NUM_LD-1) ? 0 : w+1. No grant: unchanged.
- Read pipeline: grant in cycle t sets inflight[w] and inflight_id=w at t+1. At t+1, din0 is written into resp_data[w] and resp_valid[w]<=1.
- Load latency: request handshake at t gives ld_data_valid at t+2 at the earliest.
- Response handshake:
  - resp_valid[i] clears when ld_data_valid[i] & ld_data_ready[i].
  - A capture in the same cycle as a consume leaves resp_valid=1 with the new data.
  - ld_data is held stable while valid and not ready.
- Throughput:
  - One read per cycle aggregate when two or more requesters are active.
  - At most one read every 2 cycles per requester, because of the inflight exclusion.
- Stores:
  - st_ready=1 always.
  - ce1=we1=st_valid; address1=st_addr; dout1=st_data.
  - Store and load proceed in the same cycle.
- Ordering and hazards:
  - No ordering between loads and stores; the upstream LSQ owns that.
  - Same-address read and write in the same cycle returns the old value (read-first BRAM).
- busy = |inflight | |resp_valid.

Test Plan:
- Single requester (NUM_LD=2, only req0), BRAM preloaded mem[3]=0x5A:
  - ld_addr0=3 valid at t0 -> ld_addr_ready[0]=1, ce0=1, address0=3 at t0.
  - ld_data_valid[0]=1, ld_data0=0x5A at t0+2.
  - A second request held from t0+1 is granted at t0+2 at the earliest.
- Contention: req0 (addr 1) and req1 (addr 2) both valid every cycle, ready=1:
  - Grants alternate 0,1,0,1 starting with 0 after reset.
  - One ce0 pulse every cycle; each response equals mem[addr].
- Backpressure: req0 response pending with ld_data_ready[0]=0 for 5 cycles, new req0 valid -> ld_addr_ready[0]=0 throughout; ld_data0 stays stable; req1 is still served. Then ld_data_ready[0]=1 -> req0 granted that same cycle.
- Concurrent store:
  - st_valid, st_addr=3, st_data=0x11 alongside load of addr 3 in the same cycle -> we1=1, load returns old 0x5A.
  - A load of addr 3 one cycle later returns 0x11.
- Wrap-around (NUM_LD=3): requesters 2 and 0 valid with rr_ptr=2 -> grant 2, then 0, and rr_ptr returns to 1.
- Reset mid-operation: assert rst the cycle after a grant -> ld_data_valid, busy and ce0 drop to 0 immediately (async). After release, rr_ptr=0 and no stale response appears.
